// File: rtl/msf_second_sync_if.sv
`default_nettype none
// ============================================================================
// Module      : msf_second_sync_if
// Description : Signal bundle between the MSF second synchroniser and its
//               neighbours: the carrier input and the timebase/strobe outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface msf_second_sync_if #(
    parameter int TICKS_PER_SEC = 1000
);
    localparam int W = $clog2(TICKS_PER_SEC);

    logic         carrier_i;   // synchronised, debounced carrier (1 = on)
    logic         second_o;    // one-cycle pulse as ms_o becomes 0
    logic [W-1:0] ms_o;        // millisecond within the second
    logic         sample_a_o;  // mid bit-A strobe (locked only)
    logic         sample_b_o;  // mid bit-B strobe (locked only)
    logic         locked_o;    // LOCKED or HOLDOVER
    logic [1:0]   state_o;     // HUNT=0, LOCKING=1, LOCKED=2, HOLDOVER=3

    // Drives the carrier, consumes the timebase.
    modport master (
        output carrier_i,
        input  second_o, ms_o, sample_a_o, sample_b_o, locked_o, state_o
    );

    // The synchroniser itself.
    modport slave (
        input  carrier_i,
        output second_o, ms_o, sample_a_o, sample_b_o, locked_o, state_o
    );
endinterface
`default_nettype wire

// File: rtl/msf_second_sync.sv
`default_nettype none
// ============================================================================
// Module      : msf_second_sync
// Description : Locks the local 1 kHz millisecond/second timebase to MSF
//               second edges (carrier on->off), issues the second tick and,
//               while locked, the bit-A/bit-B sample strobes. Free-runs with
//               no signal.
//               Optional feature macro: MSF_SYNC_HOLDOVER_EN (adds HOLDOVER
//               state with a missed-edge budget of HOLDOVER_MAX seconds).
// Revision    : 1.0 - initial release
// ============================================================================
module msf_second_sync #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int WINDOW_MS     = 20,
    parameter int LOCK_COUNT    = 3,
    parameter int HOLDOVER_MAX  = 8,
    parameter int SAMPLE_A_MS   = 150,
    parameter int SAMPLE_B_MS   = 250
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    msf_second_sync_if.slave bus
);
    localparam int W  = $clog2(TICKS_PER_SEC);
    localparam int GW = $clog2(LOCK_COUNT + 1);

    localparam logic [W-1:0]  c_ms_last     = W'(TICKS_PER_SEC - 1);
    localparam logic [W-1:0]  c_early_start = W'(TICKS_PER_SEC - WINDOW_MS);
    localparam logic [W-1:0]  c_late_end    = W'(WINDOW_MS);
    localparam logic [W-1:0]  c_eval_ms     = W'(WINDOW_MS + 1);
    localparam logic [W-1:0]  c_sample_a    = W'(SAMPLE_A_MS);
    localparam logic [W-1:0]  c_sample_b    = W'(SAMPLE_B_MS);
    localparam logic [GW-1:0] c_good_one    = GW'(1);
    localparam logic [GW-1:0] c_good_last   = GW'(LOCK_COUNT - 1);

    // Reject configurations the window/lock logic cannot honour.
    generate
        if (WINDOW_MS >= SAMPLE_A_MS - 100) begin : g_bad_window
            $error("msf_second_sync: WINDOW_MS must be below SAMPLE_A_MS-100");
        end
        if (LOCK_COUNT < 2) begin : g_bad_lock
            $error("msf_second_sync: LOCK_COUNT must be at least 2");
        end
        if (HOLDOVER_MAX < 1) begin : g_bad_holdover
            $error("msf_second_sync: HOLDOVER_MAX must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_HUNT     = 2'd0,
        S_LOCKING  = 2'd1,
        S_LOCKED   = 2'd2,
        S_HOLDOVER = 2'd3
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_ms;
    logic          r_second;
    logic [GW-1:0] r_good;
    logic          r_carrier_prev;
    logic          r_seen;

`ifdef MSF_SYNC_HOLDOVER_EN
    localparam int MW = $clog2(HOLDOVER_MAX + 1);
    localparam logic [MW-1:0] c_miss_one  = MW'(1);
    localparam logic [MW-1:0] c_miss_last = MW'(HOLDOVER_MAX - 1);
    logic [MW-1:0] r_miss;
`endif

    logic w_fall;
    logic w_early;
    logic w_late;
    logic w_in_win;
    logic w_eval;
    logic w_miss;
    logic w_adjust;
    logic w_locked;

    assign w_fall   = r_carrier_prev & ~bus.carrier_i;
    assign w_early  = (r_ms >= c_early_start);
    assign w_late   = (r_ms <= c_late_end);        // ms==0 counts as late
    assign w_in_win = w_early | w_late;
    assign w_eval   = (r_ms == c_eval_ms);         // window has just closed
    assign w_miss   = w_eval & ~r_seen;

    // Edges that move the phase: any edge while acquiring, in-window only once locked.
    always_comb begin
        w_adjust = 1'b0;
        case (r_state)
            S_HUNT, S_LOCKING: w_adjust = w_fall;
            default:           w_adjust = w_fall & w_in_win;
        endcase
    end

    // Millisecond counter, second tick, carrier history and window-seen flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ms           <= '0;
            r_second       <= 1'b0;
            r_carrier_prev <= 1'b1;
            r_seen         <= 1'b0;
        end else begin
            r_carrier_prev <= bus.carrier_i;
            // A late edge lands at ms 0 of a second already ticked, so no second pulse.
            if (w_adjust && w_late) begin
                r_ms     <= W'(1);
                r_second <= 1'b0;
            end else if (w_adjust || (r_ms == c_ms_last)) begin
                r_ms     <= '0;
                r_second <= 1'b1;
            end else begin
                r_ms     <= r_ms + W'(1);
                r_second <= 1'b0;
            end
            // An adjusting edge sits at phase 0 afterwards, so it also counts as seen.
            if (w_adjust) begin
                r_seen <= 1'b1;
            end else if (w_eval) begin
                r_seen <= 1'b0;
            end
        end
    end

    // Acquisition / lock state machine.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_HUNT;
            r_good  <= '0;
`ifdef MSF_SYNC_HOLDOVER_EN
            r_miss  <= '0;
`endif
        end else begin
            case (r_state)
                S_HUNT: begin
                    if (w_fall) begin
                        r_state <= S_LOCKING;
                        r_good  <= c_good_one;
                    end
                end
                S_LOCKING: begin
                    if (w_fall && w_in_win) begin
                        if (r_good == c_good_last) begin
                            r_state <= S_LOCKED;
                            r_good  <= '0;
                        end else begin
                            r_good <= r_good + c_good_one;
                        end
                    end else if (w_fall) begin
                        r_good <= c_good_one;      // restart on out-of-window edge
                    end else if (w_miss) begin
                        r_state <= S_HUNT;
                        r_good  <= '0;
                    end
                end
                S_LOCKED: begin
`ifdef MSF_SYNC_HOLDOVER_EN
                    if (w_adjust) begin
                        r_miss <= '0;
                    end else if (w_miss) begin
                        if (c_miss_last == '0) begin
                            r_state <= S_HUNT;
                            r_miss  <= '0;
                        end else begin
                            r_state <= S_HOLDOVER;
                            r_miss  <= c_miss_one;
                        end
                    end
`else
                    if (w_miss) begin
                        r_state <= S_HUNT;
                    end
`endif
                end
                S_HOLDOVER: begin
`ifdef MSF_SYNC_HOLDOVER_EN
                    if (w_adjust) begin
                        r_state <= S_LOCKED;
                        r_miss  <= '0;
                    end else if (w_miss) begin
                        if (r_miss == c_miss_last) begin
                            r_state <= S_HUNT;
                            r_miss  <= '0;
                        end else begin
                            r_miss <= r_miss + c_miss_one;
                        end
                    end
`else
                    r_state <= S_HUNT;
`endif
                end
                default: r_state <= S_HUNT;
            endcase
        end
    end

    assign w_locked       = (r_state == S_LOCKED) || (r_state == S_HOLDOVER);
    assign bus.second_o   = r_second;
    assign bus.ms_o       = r_ms;
    assign bus.state_o    = r_state;
    assign bus.locked_o   = w_locked;
    assign bus.sample_a_o = w_locked && (r_ms == c_sample_a);
    assign bus.sample_b_o = w_locked && (r_ms == c_sample_b);

endmodule
`default_nettype wire

// File: tb/tb_msf_second_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_msf_second_sync
// Description : Self-checking bench for msf_second_sync. Expected second and
//               sample strobe cycles are queued as carrier edges are planned
//               and popped as the DUT pulses. Honours MSF_SYNC_HOLDOVER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msf_second_sync;
    localparam int TICKS = 1000;
    localparam int SA    = 150;
    localparam int SB    = 250;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_sec[$];
    int   exp_sa[$];
    int   exp_sb[$];
    int   e_pop;

    msf_second_sync_if #(.TICKS_PER_SEC(TICKS)) bus ();

    msf_second_sync #(
        .TICKS_PER_SEC (TICKS),
        .WINDOW_MS     (20),
        .LOCK_COUNT    (3),
        .HOLDOVER_MAX  (8),
        .SAMPLE_A_MS   (SA),
        .SAMPLE_B_MS   (SB)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    // Cycle index: number of rising edges since reset was released.
    always @(posedge clk_i) begin
        if (!rst_ni) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe seen must match the head of its queue.
    initial forever begin
        @(negedge clk_i);
        if (bus.second_o) begin
            if (exp_sec.size() == 0) check("second_unexpected_at", cyc, -1);
            else begin e_pop = exp_sec.pop_front(); check("second_cycle", cyc, e_pop); end
        end
        if (bus.sample_a_o) begin
            if (exp_sa.size() == 0) check("sample_a_unexpected_at", cyc, -1);
            else begin e_pop = exp_sa.pop_front(); check("sample_a_cycle", cyc, e_pop); end
        end
        if (bus.sample_b_o) begin
            if (exp_sb.size() == 0) check("sample_b_unexpected_at", cyc, -1);
            else begin e_pop = exp_sb.pop_front(); check("sample_b_cycle", cyc, e_pop); end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Advance to 1 time unit after rising edge number c.
    task automatic run_to(input int c);
        if (cyc > c) check("run_to_past", cyc, c);
        while (cyc < c) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // c0 is the cycle at which ms would read 0 for the coming second.
    task automatic push_samp(input int c0);
        exp_sa.push_back(c0 + SA);
        exp_sb.push_back(c0 + SB);
    endtask

    // Falling edge detected on rising edge e; check phase/state right after.
    task automatic fall_at(input int e, input int exp_ms, input int exp_state);
        run_to(e - 1);
        bus.carrier_i = 1'b0;
        run_to(e);
        check($sformatf("edge%0d_ms", e), int'(bus.ms_o), exp_ms);
        check($sformatf("edge%0d_state", e), int'(bus.state_o), exp_state);
        check($sformatf("edge%0d_locked", e), int'(bus.locked_o), (exp_state >= 2) ? 1 : 0);
        run_to(e + 99);
        bus.carrier_i = 1'b1;
    endtask

    task automatic drain(input string tag);
        check({tag, "_sec_left"}, exp_sec.size(), 0);
        check({tag, "_sa_left"},  exp_sa.size(),  0);
        check({tag, "_sb_left"},  exp_sb.size(),  0);
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    initial begin
        bus.carrier_i = 1'b1;
        rst_ni        = 1'b0;
        release_reset();
        check("rst_ms",     int'(bus.ms_o),     0);
        check("rst_state",  int'(bus.state_o),  0);
        check("rst_locked", int'(bus.locked_o), 0);
        check("rst_second", int'(bus.second_o), 0);

        // No signal: free-running seconds, HUNT, no strobes.
        exp_sec.push_back(1000);
        exp_sec.push_back(2000);
        exp_sec.push_back(3000);
        run_to(3050);
        check("hunt_ms",    int'(bus.ms_o),    50);
        check("hunt_state", int'(bus.state_o), 0);
        drain("hunt");

        // Acquisition: edges every 1000 cycles, locked on the third.
        exp_sec.push_back(3438); fall_at(3438, 0, 1);
        exp_sec.push_back(4438); fall_at(4438, 0, 1);
        exp_sec.push_back(5438); push_samp(5438); fall_at(5438, 0, 2);
        exp_sec.push_back(6438); push_samp(6438); fall_at(6438, 0, 2);

        // 10 ms late edge: natural tick at 7438, edge re-phases to ms 1.
        exp_sec.push_back(7438); push_samp(7447); fall_at(7448, 1, 2);
        // 10 ms early edge: tick at the edge, no tick at the old wrap point.
        exp_sec.push_back(8437); push_samp(8437); fall_at(8437, 0, 2);

        // Spurious mid-second edge is ignored.
        exp_sec.push_back(9437); push_samp(9437); fall_at(9437, 0, 2);
        fall_at(9938, 501, 2);
        exp_sec.push_back(10437); push_samp(10437); fall_at(10437, 0, 2);

        // Asynchronous reset at ms 640 while locked.
        run_to(11077);
        check("pre_rst_ms",    int'(bus.ms_o),    640);
        check("pre_rst_state", int'(bus.state_o), 2);
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_ms",     int'(bus.ms_o),     0);
        check("async_rst_state",  int'(bus.state_o),  0);
        check("async_rst_locked", int'(bus.locked_o), 0);
        check("async_rst_second", int'(bus.second_o), 0);
        drain("pre_rst");
        release_reset();
        check("post_rst_ms", int'(bus.ms_o), 0);

        // Re-acquire.
        exp_sec.push_back(438);  fall_at(438, 0, 1);
        exp_sec.push_back(1438); fall_at(1438, 0, 1);
        exp_sec.push_back(2438); push_samp(2438); fall_at(2438, 0, 2);

        // Carrier edges stop.
`ifdef MSF_SYNC_HOLDOVER_EN
        for (int k = 1; k <= 3; k++) begin
            exp_sec.push_back(2438 + k * 1000);
            push_samp(2438 + k * 1000);
            if (k == 1) begin
                run_to(3459);
                check("miss1_before_eval", int'(bus.state_o), 2);
            end
            run_to(2438 + k * 1000 + 22);
            check($sformatf("hold%0d_state", k), int'(bus.state_o), 3);
            check($sformatf("hold%0d_locked", k), int'(bus.locked_o), 1);
        end
        exp_sec.push_back(6438); push_samp(6438); fall_at(6438, 0, 2);
        for (int k = 1; k <= 8; k++) begin
            exp_sec.push_back(6438 + k * 1000);
            if (k < 8) push_samp(6438 + k * 1000);
            run_to(6438 + k * 1000 + 22);
            check($sformatf("miss%0d_state", k), int'(bus.state_o), (k < 8) ? 3 : 0);
            check($sformatf("miss%0d_locked", k), int'(bus.locked_o), (k < 8) ? 1 : 0);
        end
        run_to(14700);
        drain("holdover");
`else
        exp_sec.push_back(3438);
        run_to(3459);
        check("miss_before_eval", int'(bus.state_o), 2);
        run_to(3460);
        check("miss_state",  int'(bus.state_o),  0);
        check("miss_locked", int'(bus.locked_o), 0);
        run_to(3700);
        drain("miss");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
